rf_wb_arbiter: RTL and testbench

- Write-port arbiter and scoreboard for the core's 32x32 register file, which has one synchronous write port and x0 hardwired to zero.
- Shares the single write port between two sources:
  - the main writeback stage (fixed latency, highest priority, no backpressure);
  - a long-latency unit such as the LSU (valid/ready, buffered in a small FIFO).
- Tracks registers with outstanding long-latency writes and raises decode stall for RAW/WAW hazards.

---
 rtl/rf_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with long-latency FIFO and busy scoreboard.
// Optional zero-latency LSU bypass into an empty FIFO: define RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        main_we_i,
    input  logic [4:0]  main_addr_i,
    input  logic [31:0] main_data_i,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_ready_o,
    input  logic        lsu_issue_i,
    input  logic [4:0]  lsu_issue_addr_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_we_i,
    output logic        stall_o,
    output logic        starve_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]    mem_addr_q [DEPTH];
    logic [4:0]    mem_addr_d [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [31:0]   mem_data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   busy_q, busy_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;

    logic main_claim;
    logic fifo_empty;
    logic pop;
    logic push;
    logic bypass;
    logic [4:0]  head_addr;
    logic [31:0] head_data;

    assign main_claim = main_we_i && (main_addr_i != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign lsu_ready_o = (count_q < DEPTH_C);
    assign head_addr = mem_addr_q[rd_ptr_q];
    assign head_data = mem_data_q[rd_ptr_q];
    assign pop = !main_claim && !fifo_empty;

`ifdef RF_WB_BYPASS_EN
    assign bypass = fifo_empty && !main_claim && lsu_valid_i
                    && (lsu_addr_i != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    assign push = lsu_valid_i && lsu_ready_o && (lsu_addr_i != 5'd0)
                  && !bypass;

    assign stall_o = busy_q[rs1_addr_i] | busy_q[rs2_addr_i]
                     | (rd_we_i & busy_q[rd_addr_i]);
    assign starve_o = (starve_cnt_q >= LIMIT_C);

    // Write-port mux: main first, then FIFO head, then (optionally) bypass.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = 32'd0;
        if (main_claim) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = main_addr_i;
            rf_wdata_o = main_data_i;
        end else if (pop) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = head_addr;
            rf_wdata_o = head_data;
        end else if (bypass) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = lsu_addr_i;
            rf_wdata_o = lsu_data_i;
        end
    end

    // Next-state for FIFO storage, pointers, scoreboard and starve counter.
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        busy_d       = busy_q;
        starve_cnt_d = starve_cnt_q;

        if (push) begin
            mem_addr_d[wr_ptr_q] = lsu_addr_i;
            mem_data_d[wr_ptr_q] = lsu_data_i;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            busy_d[head_addr] = 1'b0;
        end
        if (bypass) begin
            busy_d[lsu_addr_i] = 1'b0;
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // A new issue outranks a retiring write to the same register.
        if (lsu_issue_i) begin
            busy_d[lsu_issue_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (pop || fifo_empty) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    // State registers; reset drops all buffered entries and busy bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= 5'd0;
                mem_data_q[i] <= 32'd0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            busy_q       <= '0;
            starve_cnt_q <= '0;
        end else begin
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (DEPTH=2, STARVE_LIMIT=4).
// Inputs change after negedge; outputs are sampled mid-low-phase.
module tb_rf_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        main_we_i;
    logic [4:0]  main_addr_i;
    logic [31:0] main_data_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_addr_i;
    logic [31:0] lsu_data_i;
    logic        lsu_ready_o;
    logic        lsu_issue_i;
    logic [4:0]  lsu_issue_addr_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [4:0]  rd_addr_i;
    logic        rd_we_i;
    logic        stall_o;
    logic        starve_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    int n_assert = 0;
    int n_fail   = 0;

    rf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .main_we_i        (main_we_i),
        .main_addr_i      (main_addr_i),
        .main_data_i      (main_data_i),
        .lsu_valid_i      (lsu_valid_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_data_i       (lsu_data_i),
        .lsu_ready_o      (lsu_ready_o),
        .lsu_issue_i      (lsu_issue_i),
        .lsu_issue_addr_i (lsu_issue_addr_i),
        .rs1_addr_i       (rs1_addr_i),
        .rs2_addr_i       (rs2_addr_i),
        .rd_addr_i        (rd_addr_i),
        .rd_we_i          (rd_we_i),
        .stall_o          (stall_o),
        .starve_o         (starve_o),
        .rf_we_o          (rf_we_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic main_set(input logic we, input logic [4:0] a,
                            input logic [31:0] d);
        main_we_i   = we;
        main_addr_i = a;
        main_data_i = d;
    endtask

    task automatic lsu_set(input logic v, input logic [4:0] a,
                           input logic [31:0] d);
        lsu_valid_i = v;
        lsu_addr_i  = a;
        lsu_data_i  = d;
    endtask

    initial begin
        rst_i = 1'b1;
        main_set(1'b0, 5'd0, 32'd0);
        lsu_set(1'b0, 5'd0, 32'd0);
        lsu_issue_i = 1'b0;
        lsu_issue_addr_i = 5'd0;
        rs1_addr_i = 5'd0;
        rs2_addr_i = 5'd0;
        rd_addr_i  = 5'd0;
        rd_we_i    = 1'b0;

        // Reset and idle
        step(); step(); settle();
        check("rst_we", 32'(rf_we_o), 32'd0);
        check("rst_ready", 32'(lsu_ready_o), 32'd1);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_starve", 32'(starve_o), 32'd0);
        rst_i = 1'b0;
        step(); settle();
        check("idle_we", 32'(rf_we_o), 32'd0);
        check("idle_waddr", 32'(rf_waddr_o), 32'd0);

        // Main priority over a buffered LSU entry
        main_set(1'b1, 5'd5, 32'hAAAA0000);
        lsu_set(1'b1, 5'd7, 32'h12345678);
        settle();
        check("main_we", 32'(rf_we_o), 32'd1);
        check("main_waddr", 32'(rf_waddr_o), 32'd5);
        check("main_wdata", rf_wdata_o, 32'hAAAA0000);
        step();
        lsu_set(1'b0, 5'd0, 32'd0);
        settle();
        check("main_hold_waddr", 32'(rf_waddr_o), 32'd5);
        step();
        main_set(1'b0, 5'd0, 32'd0);
        settle();
        check("drain7_we", 32'(rf_we_o), 32'd1);
        check("drain7_waddr", 32'(rf_waddr_o), 32'd7);
        check("drain7_wdata", rf_wdata_o, 32'h12345678);
        step(); settle();
        check("after7_we", 32'(rf_we_o), 32'd0);
        check("after7_wdata", rf_wdata_o, 32'd0);

        // Backpressure with DEPTH=2
        main_set(1'b1, 5'd3, 32'h33);
        lsu_set(1'b1, 5'd8, 32'd1);
        settle();
        check("bp_ready0", 32'(lsu_ready_o), 32'd1);
        step();
        lsu_set(1'b1, 5'd9, 32'd2);
        settle();
        check("bp_ready1", 32'(lsu_ready_o), 32'd1);
        step();
        lsu_set(1'b1, 5'd10, 32'd3);
        settle();
        check("bp_full", 32'(lsu_ready_o), 32'd0);
        check("bp_main_waddr", 32'(rf_waddr_o), 32'd3);
        step();
        main_set(1'b0, 5'd0, 32'd0);
        settle();
        check("bp_d8_waddr", 32'(rf_waddr_o), 32'd8);
        check("bp_d8_wdata", rf_wdata_o, 32'd1);
        check("bp_d8_ready", 32'(lsu_ready_o), 32'd0);
        step(); settle();
        check("bp_d9_waddr", 32'(rf_waddr_o), 32'd9);
        check("bp_d9_wdata", rf_wdata_o, 32'd2);
        check("bp_d9_ready", 32'(lsu_ready_o), 32'd1);
        step();
        lsu_set(1'b0, 5'd0, 32'd0);
        settle();
        check("bp_d10_waddr", 32'(rf_waddr_o), 32'd10);
        check("bp_d10_wdata", rf_wdata_o, 32'd3);
        step(); settle();
        check("bp_empty_we", 32'(rf_we_o), 32'd0);
        check("bp_empty_ready", 32'(lsu_ready_o), 32'd1);

        // Scoreboard: issue, stall, clear on write
        lsu_issue_i = 1'b1;
        lsu_issue_addr_i = 5'd10;
        rs1_addr_i = 5'd10;
        settle();
        check("sb_pre_stall", 32'(stall_o), 32'd0);
        step();
        lsu_issue_i = 1'b0;
        main_set(1'b1, 5'd3, 32'h33);
        lsu_set(1'b1, 5'd10, 32'hA);
        settle();
        check("sb_busy_stall", 32'(stall_o), 32'd1);
        step();
        main_set(1'b0, 5'd0, 32'd0);
        lsu_set(1'b0, 5'd0, 32'd0);
        settle();
        check("sb_wr_cycle_waddr", 32'(rf_waddr_o), 32'd10);
        check("sb_wr_cycle_stall", 32'(stall_o), 32'd1);
        step(); settle();
        check("sb_cleared", 32'(stall_o), 32'd0);

        // Issue and pop of the same register in one cycle
        lsu_issue_i = 1'b1;
        lsu_issue_addr_i = 5'd10;
        main_set(1'b1, 5'd3, 32'h33);
        lsu_set(1'b1, 5'd10, 32'hB);
        step();
        main_set(1'b0, 5'd0, 32'd0);
        lsu_set(1'b0, 5'd0, 32'd0);
        settle();
        check("sb_same_waddr", 32'(rf_waddr_o), 32'd10);
        check("sb_same_stall", 32'(stall_o), 32'd1);
        step();
        lsu_issue_i = 1'b0;
        settle();
        check("sb_set_wins", 32'(stall_o), 32'd1);
        check("sb_set_wins_we", 32'(rf_we_o), 32'd0);
        lsu_set(1'b1, 5'd10, 32'hC);
        step();
        lsu_set(1'b0, 5'd0, 32'd0);
`ifndef RF_WB_BYPASS_EN
        settle();
        check("sb_c_waddr", 32'(rf_waddr_o), 32'd10);
        check("sb_c_wdata", rf_wdata_o, 32'hC);
`endif
        step(); settle();
        check("sb_c_cleared", 32'(stall_o), 32'd0);

        // rd hazard only when rd_we_i
        rs1_addr_i = 5'd0;
        lsu_issue_i = 1'b1;
        lsu_issue_addr_i = 5'd12;
        step();
        lsu_issue_i = 1'b0;
        rd_addr_i = 5'd12;
        rd_we_i = 1'b0;
        settle();
        check("rd_no_we", 32'(stall_o), 32'd0);
        rd_we_i = 1'b1;
        settle();
        check("rd_we", 32'(stall_o), 32'd1);
        rd_we_i = 1'b0;
        rs2_addr_i = 5'd12;
        settle();
        check("rs2_stall", 32'(stall_o), 32'd1);
        rs2_addr_i = 5'd0;
        rd_addr_i = 5'd0;

        // Issue to x0 never stalls
        lsu_issue_i = 1'b1;
        lsu_issue_addr_i = 5'd0;
        step();
        lsu_issue_i = 1'b0;
        settle();
        check("x0_issue_stall", 32'(stall_o), 32'd0);

        // Starvation with STARVE_LIMIT=4
        main_set(1'b1, 5'd4, 32'h44);
        lsu_set(1'b1, 5'd13, 32'hD);
        step();
        lsu_set(1'b0, 5'd0, 32'd0);
        step(); step(); step();
        settle();
        check("starve_3", 32'(starve_o), 32'd0);
        step(); settle();
        check("starve_4", 32'(starve_o), 32'd1);
        check("starve_main_waddr", 32'(rf_waddr_o), 32'd4);
        step();
        main_set(1'b0, 5'd0, 32'd0);
        settle();
        check("starve_pop_waddr", 32'(rf_waddr_o), 32'd13);
        check("starve_pop_flag", 32'(starve_o), 32'd1);
        step(); settle();
        check("starve_clear", 32'(starve_o), 32'd0);
        check("starve_clear_we", 32'(rf_we_o), 32'd0);

        // LSU write to x0: accepted, dropped
        lsu_set(1'b1, 5'd0, 32'hFF);
        settle();
        check("x0_ready", 32'(lsu_ready_o), 32'd1);
        check("x0_we", 32'(rf_we_o), 32'd0);
        step();
        lsu_set(1'b0, 5'd0, 32'd0);
        settle();
        check("x0_after_we", 32'(rf_we_o), 32'd0);

        // Reset with a full FIFO and a busy register
        main_set(1'b1, 5'd3, 32'h33);
        lsu_set(1'b1, 5'd14, 32'hE);
        lsu_issue_i = 1'b1;
        lsu_issue_addr_i = 5'd16;
        step();
        lsu_issue_i = 1'b0;
        lsu_set(1'b1, 5'd15, 32'hF);
        step();
        lsu_set(1'b0, 5'd0, 32'd0);
        rs1_addr_i = 5'd16;
        settle();
        check("prerst_full", 32'(lsu_ready_o), 32'd0);
        check("prerst_stall", 32'(stall_o), 32'd1);
        main_set(1'b0, 5'd0, 32'd0);
        rst_i = 1'b1;
        settle();
        check("midrst_ready", 32'(lsu_ready_o), 32'd1);
        check("midrst_we", 32'(rf_we_o), 32'd0);
        check("midrst_stall", 32'(stall_o), 32'd0);
        step();
        rst_i = 1'b0;
        rs1_addr_i = 5'd0;
        settle();
        check("postrst_we0", 32'(rf_we_o), 32'd0);
        step(); settle();
        check("postrst_we1", 32'(rf_we_o), 32'd0);
        check("postrst_ready", 32'(lsu_ready_o), 32'd1);

        // LSU into an empty FIFO: bypass or 1-cycle latency
        lsu_set(1'b1, 5'd6, 32'h55);
        settle();
`ifdef RF_WB_BYPASS_EN
        check("byp_we", 32'(rf_we_o), 32'd1);
        check("byp_waddr", 32'(rf_waddr_o), 32'd6);
        check("byp_wdata", rf_wdata_o, 32'h55);
        step();
        lsu_set(1'b0, 5'd0, 32'd0);
        settle();
        check("byp_no_dup", 32'(rf_we_o), 32'd0);
`else
        check("lat_we0", 32'(rf_we_o), 32'd0);
        step();
        lsu_set(1'b0, 5'd0, 32'd0);
        settle();
        check("lat_we1", 32'(rf_we_o), 32'd1);
        check("lat_waddr", 32'(rf_waddr_o), 32'd6);
        check("lat_wdata", rf_wdata_o, 32'h55);
`endif
        step(); settle();
        check("final_idle", 32'(rf_we_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
